hashcore_sched: RTL
===================

Name: hashcore_sched

Overview:
Parametrised nonce scheduler and golden-nonce collector, the successor to the single-core hashcore wrapper. It drives NUM_CORES external hash cores (whirlpool or equivalent) over a programmable inclusive nonce range, giving each core a distinct interleaved nonce every cycle. It collects match results from the cores through per-core pending registers into a golden-nonce FIFO with a ready/valid pop interface. It sits between the comm block (new_work, range, FIFO drain) and the core array.

Parameters:
NUM_CORES, 4, number of cores; power of 2, 1..16.
FIFO_DEPTH, 8, golden-nonce FIFO entries; power of 2, ≥2.
DRAIN_CYCLES, 80, core pipeline latency; the collection window held open after the last nonce is issued.

Ports:
hash_clk  in  1  sole clock.
reset_n  in  1  asynchronous, active-low reset.
new_work  in  1  level from the clk_comm domain; 2-flop synchronised internally, rising edge starts a job.
nonce_start  in  32  first nonce, inclusive, sampled in LOAD.
nonce_end  in  32  last nonce, inclusive, sampled in LOAD.
core_start  out  NUM_CORES  one-cycle pulse to every core in LOAD (new_work to the core).
core_nonce  out  NUM_CORES*32  slice i = base + i (mod 2^32).
core_en  out  NUM_CORES  bit i: slice i is in range and valid this cycle.
core_match  in  NUM_CORES  per-core match strobe.
core_nonce_out  in  NUM_CORES*32  per-core matching nonce, valid with core_match.
gn_data  out  32  FIFO head.
gn_valid  out  1  FIFO not empty.
gn_ready  in  1  pop; an entry is popped when gn_valid && gn_ready.
gn_overflow  out  1  sticky; a match was dropped. Cleared in LOAD.
miner_busy  out  1  high from LOAD until DRAIN exits.
range_done  out  1  one-cycle pulse on DRAIN→IDLE.

Behaviour:
- Reset values (reset_n low, async): state IDLE; all outputs 0; FIFO empty; pendings empty; base=0; sync flops 0.
- Start detection: new_work passes 2 flops, then an edge register. The edge is asserted in the 3rd hash_clk edge after new_work rises. Holding new_work high does not re-trigger.
- IDLE: core_en=0. Matches are ignored. On edge → LOAD.
- LOAD, 1 cycle:
  - base←nonce_start, end_r←nonce_end.
  - FIFO and pendings flushed; gn_overflow←0; core_start=all 1s; miner_busy←1.
  - If nonce_start>nonce_end → DRAIN (empty range); else → RUN.
- RUN:
  - core_en[i] = ({1'b0,base}+i ≤ {1'b0,end_r}), computed at 33 bits.
  - Each cycle base←base+NUM_CORES.
  - Last group: {1'b0,base}+NUM_CORES-1 ≥ end_r, or the 33-bit base+NUM_CORES carries. → DRAIN, with a counter loaded to DRAIN_CYCLES-1.
  - Range end 0xFFFFFFFF completes with no wrap re-issue.
- DRAIN: core_en=0. Counter decrements. At 0 → IDLE, range_done=1, miner_busy←0 in the same cycle.
- An edge in RUN or DRAIN aborts → LOAD; the flush discards in-flight results and range_done does not pulse. An edge in LOAD is absorbed.
- Match capture (RUN and DRAIN only):
  - core_match[i] loads pending[i] with core_nonce_out[i].
  - If pending[i] is already full and not being drained this cycle, the new result is dropped and gn_overflow←1.
- Arbiter: round-robin. At most one pending entry moves to the FIFO per cycle, and only if the FIFO is not full or a pop occurs in the same cycle. The pointer advances past the granted core.
- Capture-to-gn_valid latency with an empty FIFO: 2 cycles (pending, then FIFO).
- FIFO: first-word-fall-through. Simultaneous push and pop is legal at full and at empty (when empty, data is not bypassed). Pending entries stall while the FIFO is full.

Test Plan:
- NUM_CORES=4, start=0x100, end=0x10B, no matches → core_nonce slice 0 = 0x100, 0x104, 0x108 on consecutive RUN cycles, core_en=4'hF throughout; then DRAIN_CYCLES cycles later range_done pulses once and miner_busy falls.
- start=0xFFFFFFFE, end=0xFFFFFFFF → one RUN cycle, core_en=4'b0011, no second issue, range_done follows.
- start=5, end=4 → LOAD then DRAIN with core_en never set; range_done after DRAIN_CYCLES.
- core_match=4'hF in one cycle with nonces 0xA0..0xA3, gn_ready=1 → gn_data sequence 0xA0, 0xA1, 0xA2, 0xA3, one per cycle, gn_overflow=0.
- FIFO_DEPTH=8, gn_ready=0, 8 matches from core 0, then two more from core 0 → FIFO full, pending[0] holds the 9th, the 10th is dropped, gn_overflow=1; raise gn_ready → 9 entries drain in order.
- Mid-RUN new_work re-edge with start=0x200 → LOAD; FIFO emptied; gn_valid=0; next slice 0 = 0x200; no range_done for the aborted job. Asserting reset_n low mid-RUN → all outputs 0 immediately.

Source files
------------

// File: rtl/hashcore_sched.sv
// Nonce scheduler and golden-nonce collector for an array of NUM_CORES hash cores.
// Issues interleaved nonces over an inclusive range and funnels core matches into a FWFT FIFO.
module hashcore_sched #(
  parameter int NUM_CORES    = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int DRAIN_CYCLES = 80
) (
  input  logic                    hash_clk,
  input  logic                    reset_n,
  input  logic                    new_work,
  input  logic [31:0]             nonce_start,
  input  logic [31:0]             nonce_end,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [NUM_CORES*32-1:0] core_nonce,
  output logic [NUM_CORES-1:0]    core_en,
  input  logic [NUM_CORES-1:0]    core_match,
  input  logic [NUM_CORES*32-1:0] core_nonce_out,
  output logic [31:0]             gn_data,
  output logic                    gn_valid,
  input  logic                    gn_ready,
  output logic                    gn_overflow,
  output logic                    miner_busy,
  output logic                    range_done,
  output logic [1:0]              dbg_state
);

  // gn_valid/gn_ready: an entry transfers on every cycle both are high; while gn_valid is
  // high and gn_ready low, gn_data holds the same head entry.

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                r_state;
  logic [31:0]           r_base;
  logic [31:0]           r_end;
  logic [DW-1:0]         r_cnt;
  logic [NUM_CORES-1:0]  r_core_start;
  logic                  r_busy;
  logic                  r_done;

  logic                  r_nw_s1;
  logic                  r_nw_s2;
  logic                  r_nw_s3;
  logic                  r_edge;

  logic [NUM_CORES-1:0]  r_pend_v;
  logic [31:0]           r_pend_d [NUM_CORES];
  logic [PW-1:0]         r_rr_ptr;
  logic [31:0]           r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_ovf;

  logic                  w_go_load;
  logic [32:0]           w_base33;
  logic [32:0]           w_end33;
  logic [32:0]           w_next33;
  logic                  w_last;
  logic [NUM_CORES-1:0]  w_en;
  logic [31:0]           w_nout [NUM_CORES];
  logic                  w_cap_en;
  logic                  w_pop;
  logic                  w_can_push;
  logic                  w_gnt_vld;
  logic [PW-1:0]         w_gnt_idx;
  logic [NUM_CORES-1:0]  w_pend_v_nxt;
  logic [NUM_CORES-1:0]  w_load;
  logic                  w_ovf_set;

  // Two synchroniser flops, then an edge register: the pulse lands on the 3rd clock edge.
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_nw_s1 <= 1'b0;
      r_nw_s2 <= 1'b0;
      r_nw_s3 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_nw_s1 <= new_work;
      r_nw_s2 <= r_nw_s1;
      r_nw_s3 <= r_nw_s2;
      r_edge  <= r_nw_s2 & ~r_nw_s3;
    end
  end

  // An edge while already in LOAD is absorbed.
  assign w_go_load = r_edge && (r_state != S_LOAD);

  assign w_base33 = {1'b0, r_base};
  assign w_end33  = {1'b0, r_end};
  assign w_next33 = w_base33 + 33'(NUM_CORES);
  assign w_last   = ((w_base33 + 33'(NUM_CORES - 1)) >= w_end33) || w_next33[32];

  // Nonce slices are forced to zero outside RUN so an idle scheduler presents all-zero outputs.
  always_comb begin
    w_en       = '0;
    core_nonce = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_en[i]              = (r_state == S_RUN) && ((w_base33 + 33'(i)) <= w_end33);
      core_nonce[i*32 +: 32] = (r_state == S_RUN) ? (r_base + 32'(i)) : 32'd0;
      w_nout[i]            = core_nonce_out[i*32 +: 32];
    end
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_end        <= '0;
      r_cnt        <= '0;
      r_core_start <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_core_start <= '0;
      r_done       <= 1'b0;
      if (w_go_load) begin
        r_state      <= S_LOAD;
        r_core_start <= '1;
        r_busy       <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: ;
          S_LOAD: begin
            r_base <= nonce_start;
            r_end  <= nonce_end;
            if (nonce_start > nonce_end) begin
              r_state <= S_DRAIN;
              r_cnt   <= DW'(DRAIN_CYCLES - 1);
            end else begin
              r_state <= S_RUN;
            end
          end
          S_RUN: begin
            r_base <= w_next33[31:0];
            if (w_last) begin
              r_state <= S_DRAIN;
              r_cnt   <= DW'(DRAIN_CYCLES - 1);
            end
          end
          S_DRAIN: begin
            if (r_cnt == '0) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt - DW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign w_cap_en   = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_pop      = gn_valid && gn_ready;
  assign w_can_push = (r_count < CW'(FIFO_DEPTH)) || w_pop;

  // Round-robin search starting at the pointer; a full FIFO stalls all pending entries.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!w_gnt_vld && w_can_push && r_pend_v[(int'(r_rr_ptr) + k) % NUM_CORES]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = PW'((int'(r_rr_ptr) + k) % NUM_CORES);
      end
    end
  end

  // A pending slot being drained this cycle can accept a new result.
  always_comb begin
    w_pend_v_nxt = r_pend_v;
    w_load       = '0;
    w_ovf_set    = 1'b0;
    if (w_gnt_vld) w_pend_v_nxt[w_gnt_idx] = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_cap_en && core_match[i]) begin
        if (r_pend_v[i] && !(w_gnt_vld && (w_gnt_idx == PW'(i)))) begin
          w_ovf_set = 1'b1;
        end else begin
          w_pend_v_nxt[i] = 1'b1;
          w_load[i]       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_v <= '0;
      r_rr_ptr <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) r_pend_d[i] <= '0;
    end else if (w_go_load) begin
      r_pend_v <= '0;
      r_rr_ptr <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_pend_v <= w_pend_v_nxt;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_load[i]) r_pend_d[i] <= w_nout[i];
      end
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_gnt_vld) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_rr_ptr <= PW'((int'(w_gnt_idx) + 1) % NUM_CORES);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_gnt_vld, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge hash_clk) begin
    if (w_gnt_vld && !w_go_load) r_mem[r_wr_ptr] <= r_pend_d[w_gnt_idx];
  end

  assign gn_valid    = (r_count != '0);
  assign gn_data     = gn_valid ? r_mem[r_rd_ptr] : 32'd0;
  assign gn_overflow = r_ovf;
  assign core_start  = r_core_start;
  assign core_en     = w_en;
  assign miner_busy  = r_busy;
  assign range_done  = r_done;
  assign dbg_state   = r_state;

endmodule
